// File: rtl/input_conditioner.sv
// Synchronises and debounces the Basys 3 pause button and speed switch for the up-counter.
// Optional long-press clear is built when INPUT_CONDITIONER_LONG_PRESS_CLR_EN is defined.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 200000000
) (
  input  logic intClk,
  input  logic reset,
  input  logic btnPause,
  input  logic swSpeed,
  output logic pause,
  output logic speed,
  output logic pausePulse,
  output logic clrPulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  logic          btnMeta;
  logic          syncBtn;
  logic          swMeta;
  logic          syncSw;
  btn_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] scnt;

`ifdef INPUT_CONDITIONER_LONG_PRESS_CLR_EN
  localparam int            HW        = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic [HW-1:0] hcnt;
`else
  logic unusedLongCfg;
  assign unusedLongCfg = (LONG_CYCLES > DEBOUNCE_CYCLES);
  assign clrPulse      = 1'b0;
`endif

  // Two-flop synchronisers for both asynchronous board inputs.
  always_ff @(posedge intClk or posedge reset) begin
    if (reset) begin
      btnMeta <= 1'b0;
      syncBtn <= 1'b0;
      swMeta  <= 1'b0;
      syncSw  <= 1'b0;
    end else begin
      btnMeta <= btnPause;
      syncBtn <= btnMeta;
      swMeta  <= swSpeed;
      syncSw  <= swMeta;
    end
  end

  // Button debounce FSM: one pause toggle per qualified press, optional long-press clear.
  always_ff @(posedge intClk or posedge reset) begin
    if (reset) begin
      state      <= RELEASED;
      cnt        <= '0;
      pause      <= 1'b0;
      pausePulse <= 1'b0;
`ifdef INPUT_CONDITIONER_LONG_PRESS_CLR_EN
      hcnt       <= '0;
      clrPulse   <= 1'b0;
`endif
    end else begin
      pausePulse <= 1'b0;
`ifdef INPUT_CONDITIONER_LONG_PRESS_CLR_EN
      clrPulse   <= 1'b0;
`endif
      case (state)
        RELEASED: begin
`ifdef INPUT_CONDITIONER_LONG_PRESS_CLR_EN
          hcnt <= '0;
`endif
          if (syncBtn) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end else begin
            state <= RELEASED;
          end
        end
        PRESS_WAIT: begin
          if (!syncBtn) begin
            state <= RELEASED;
          end else if (cnt == CNT_LAST) begin
            state      <= PRESSED;
            pausePulse <= 1'b1;
            pause      <= ~pause;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            cnt <= cnt;
          end
        end
        PRESSED: begin
`ifdef INPUT_CONDITIONER_LONG_PRESS_CLR_EN
          // Hold counter parks at HOLD_MAX after firing so one press clears at most once.
          if (hcnt == HOLD_LAST) begin
            hcnt     <= HOLD_MAX;
            clrPulse <= 1'b1;
            pause    <= 1'b0;
          end else if (hcnt != HOLD_MAX) begin
            hcnt <= hcnt + HOLD_ONE;
          end else begin
            hcnt <= hcnt;
          end
`endif
          if (!syncBtn) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else begin
            state <= PRESSED;
          end
        end
        RELEASE_WAIT: begin
          if (syncBtn) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state <= RELEASED;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            cnt <= cnt;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Speed level follows the switch once it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge intClk or posedge reset) begin
    if (reset) begin
      speed <= 1'b0;
      scnt  <= '0;
    end else if (syncSw == speed) begin
      scnt <= '0;
    end else if (scnt == CNT_LAST) begin
      speed <= syncSw;
      scnt  <= '0;
    end else if (scnt != CNT_MAX) begin
      scnt <= scnt + CNT_ONE;
    end else begin
      scnt <= scnt;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_input_conditioner;

  logic intClk;
  logic reset;
  logic btnPause;
  logic swSpeed;
  logic pause;
  logic speed;
  logic pausePulse;
  logic clrPulse;

  int checks = 0;
  int errors = 0;

  logic pexp = 1'b0;
  logic sexp = 1'b0;

  string      tagQ[$];
  logic [3:0] valQ[$];

  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ZEROS = 64'h0;

`ifdef INPUT_CONDITIONER_LONG_PRESS_CLR_EN
  localparam int CLR_EDGE = 27;
`else
  localparam int CLR_EDGE = 0;
`endif

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20)
  ) dut (
    .intClk(intClk),
    .reset(reset),
    .btnPause(btnPause),
    .swSpeed(swSpeed),
    .pause(pause),
    .speed(speed),
    .pausePulse(pausePulse),
    .clrPulse(clrPulse)
  );

  initial intClk = 1'b0;
  always #5 intClk = ~intClk;

  // Queue the expected {pause,speed,pausePulse,clrPulse} for n edges, then drive and compare.
  task automatic run_seq(input string tag, input logic [63:0] bpat, input logic [63:0] spat,
                         input int n, input int ppEdge, input int spEdge, input int cpEdge);
    string      t;
    logic [3:0] e;
    for (int i = 1; i <= n; i++) begin
      if (i == ppEdge) pexp = ~pexp;
      if (i == spEdge) sexp = ~sexp;
      if (i == cpEdge) pexp = 1'b0;
      tagQ.push_back(tag);
      valQ.push_back({pexp, sexp, (i == ppEdge), (i == cpEdge)});
    end
    for (int i = 1; i <= n; i++) begin
      btnPause = bpat[i-1];
      swSpeed  = spat[i-1];
      @(posedge intClk);
      #1;
      t = tagQ.pop_front();
      e = valQ.pop_front();
      checks++;
      assert ({pause, speed, pausePulse, clrPulse} === e) else begin
        errors++;
        $error("FAIL %s edge %0d: observed pause/speed/pp/clr=%b expected %b",
               t, i, {pause, speed, pausePulse, clrPulse}, e);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert ({pause, speed, pausePulse, clrPulse} === 4'b0000) else begin
      errors++;
      $error("FAIL %s: observed pause/speed/pp/clr=%b expected 0000", tag,
             {pause, speed, pausePulse, clrPulse});
    end
  endtask

  initial begin
    reset    = 1'b1;
    btnPause = 1'b0;
    swSpeed  = 1'b0;
    #2;
    check_zero("rst_init");
    @(negedge intClk);
    reset = 1'b0;

    run_seq("clean_press",    ONES,  ZEROS, 22, 7, 0, 0);
    run_seq("clean_release",  ZEROS, ZEROS, 10, 0, 0, 0);
    run_seq("second_press",   ONES,  ZEROS, 12, 7, 0, 0);
    run_seq("second_release", ZEROS, ZEROS, 10, 0, 0, 0);
    // raw 1,0,1,1,0 then stable 1s: pulse 4 edges after the synchronised stable run starts
    run_seq("bounce_press",   64'h3FED, ZEROS, 14, 12, 0, 0);
    run_seq("release_glitch", 64'h2,    ZEROS, 12, 0, 0, 0);

    run_seq("speed_rise",     ZEROS, ONES,  10, 0, 6, 0);
    run_seq("speed_fall",     ZEROS, ZEROS, 10, 0, 6, 0);
    // raw 1,1,0,1,... restarts qualification; speed rises 6 edges after the 0
    run_seq("speed_glitch",   ZEROS, 64'h3FFB, 14, 0, 9, 0);
    run_seq("speed_fall2",    ZEROS, ZEROS, 10, 0, 6, 0);

    run_seq("simultaneous",   ONES,  ONES,  12, 7, 6, 0);
    run_seq("simul_release",  ZEROS, ONES,  10, 0, 0, 0);
    run_seq("prep_press",     ONES,  ONES,  10, 7, 0, 0);

    // Asynchronous reset mid-cycle while pause=1 and speed=1
    #3;
    reset = 1'b1;
    #1;
    check_zero("rst_async");
    pexp = 1'b0;
    sexp = 1'b0;
    run_seq("rst_hold",       ONES,  ONES,  2, 0, 0, 0);
    @(negedge intClk);
    reset = 1'b0;
    run_seq("post_reset",     ONES,  ONES,  10, 7, 6, 0);
    run_seq("post_reset_rel", ZEROS, ONES,  10, 0, 0, 0);

    run_seq("long_press",     ONES,  ONES,  40, 7, 0, CLR_EDGE);
    run_seq("long_release",   ZEROS, ONES,  10, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
